// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - seven-segment display bus readback and BCD digit recovery
//
// Purpose: samples a multiplexed, active-low, common-anode seven-segment bus,
// filters anode-scan glitches with a stability counter, and latches the
// decoded value of each digit position.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous active-low reset
//   seg[6:0]     segment lines, active-low, bit0=a .. bit6=g
//   an[N-1:0]    digit enables, active-low, one low = digit selected
//   clr          clears digit_valid, err_flag and frame mask (digits kept)
//   digits       latched value of digit i at [4i+3:4i]
//   digit_valid  digit i latched since reset/clr
//   code_err     one-cycle pulse on a filtered illegal pattern
//   err_flag     sticky code_err
//   frame_done   one-cycle pulse once every digit has latched
module seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    code_err,
  output logic                    err_flag,
  output logic                    frame_done
);

  localparam logic [7:0] STABLE8 = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;

  state_e                  state_q, state_d;
  logic [6:0]              s_seg_q;
  logic [NUM_DIGITS-1:0]   s_an_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    code_err_q, code_err_d;
  logic                    err_q, err_d;
  logic                    frame_q, frame_d;

  logic [3:0]              dec_val;
  logic                    dec_legal;
  logic                    dec_blank;
  logic                    an_hot_in;
  logic                    s_hot;
  logic                    act;
  logic                    latch;
  logic                    illegal;
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   latch_bits;
  logic [NUM_DIGITS-1:0]   seen_base;
  logic                    seen_full;

  function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!a[i]) n++;
    end
    return n == 1;
  endfunction

  // Pattern bits are {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    dec_val   = 4'h0;
    dec_legal = 1'b0;
    dec_blank = 1'b0;
    case (s_seg_q)
      7'b1000000: begin dec_val = 4'h0; dec_legal = 1'b1; end
      7'b1111001: begin dec_val = 4'h1; dec_legal = 1'b1; end
      7'b0100100: begin dec_val = 4'h2; dec_legal = 1'b1; end
      7'b0110000: begin dec_val = 4'h3; dec_legal = 1'b1; end
      7'b0011001: begin dec_val = 4'h4; dec_legal = 1'b1; end
      7'b0010010: begin dec_val = 4'h5; dec_legal = 1'b1; end
      7'b0000010: begin dec_val = 4'h6; dec_legal = 1'b1; end
      7'b1111000: begin dec_val = 4'h7; dec_legal = 1'b1; end
      7'b0000000: begin dec_val = 4'h8; dec_legal = 1'b1; end
      7'b0010000: begin dec_val = 4'h9; dec_legal = 1'b1; end
      7'b0111111: begin dec_val = 4'hF; dec_legal = 1'b1; end
      7'b1111111: dec_blank = 1'b1;
      default:    ;
    endcase
  end

  // The counter compares the incoming pair against the one being replaced, so
  // cnt_q always counts consecutive identical samples held in s_seg_q/s_an_q.
  always_comb begin
    an_hot_in = one_hot_low(an);
    cnt_d     = 8'd0;
    if (an_hot_in && (seg == s_seg_q) && (an == s_an_q)) begin
      cnt_d = (cnt_q == STABLE8) ? cnt_q : cnt_q + 8'd1;
    end else if (an_hot_in) begin
      cnt_d = 8'd1;
    end
  end

  always_comb begin
    s_hot   = one_hot_low(s_an_q);
    state_d = state_q;
    act     = 1'b0;
    case (state_q)
      IDLE:  if (s_hot) state_d = TRACK;
      TRACK: begin
        if (!s_hot) begin
          state_d = IDLE;
        end else if (cnt_q == STABLE8) begin
          act     = 1'b1;
          state_d = HELD;
        end
      end
      // A saturated counter only drops when the sampled pair changes.
      HELD: begin
        if (!s_hot) state_d = IDLE;
        else if (cnt_q != STABLE8) state_d = TRACK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    latch      = act && dec_legal;
    illegal    = act && !dec_legal && !dec_blank;
    sel        = ~s_an_q;
    latch_bits = latch ? sel : '0;

    digits_d = digits_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (latch_bits[i]) digits_d[4*i +: 4] = dec_val;
    end

    // A full mask is cleared on the edge that emits frame_done; a latch on
    // that same edge lands in the fresh mask.
    seen_full  = &seen_q;
    seen_base  = seen_full ? '0 : seen_q;
    seen_d     = clr ? '0 : (seen_base | latch_bits);
    frame_d    = seen_full && !clr;

    valid_d    = clr ? '0 : (valid_q | latch_bits);
    code_err_d = illegal;
    err_d      = clr ? 1'b0 : (err_q | illegal);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_seg_q    <= '1;
      s_an_q     <= '1;
      cnt_q      <= 8'd0;
      digits_q   <= '0;
      valid_q    <= '0;
      seen_q     <= '0;
      code_err_q <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_seg_q    <= seg;
      s_an_q     <= an;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
      code_err_q <= code_err_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign code_err    = code_err_q;
  assign err_flag    = err_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed self-checking bench for seg_capture
module tb_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        code_err;
  logic        err_flag;
  logic        frame_done;

  int total;
  int bad;
  int fd_cnt;
  int ce_cnt;

  logic [6:0] pat [4];

  seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .clr         (clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .err_flag    (err_flag),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (code_err) ce_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    fd_cnt = 0;
    ce_cnt = 0;
    pat[0] = 7'b1111001;
    pat[1] = 7'b0100100;
    pat[2] = 7'b0110000;
    pat[3] = 7'b0011001;
    clk    = 1'b0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    seg    = 7'b0000000;
    an     = 4'b1110;

    // Reset
    repeat (3) tick();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_valid", digit_valid, 4'h0);
    chk("rst_code_err", code_err, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);

    // First latch exactly on edge 5 after release
    rst_n = 1'b1;
    repeat (4) tick();
    chk("lat_edge4_valid", digit_valid, 4'h0);
    tick();
    chk("lat_edge5_valid", digit_valid, 4'h1);
    chk("lat_edge5_digit", digits[3:0], 4'h8);

    // Scan 1,2,3,4 across all digits
    fd_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      an  = ~(4'b0001 << d);
      seg = pat[d];
      for (int t = 1; t <= 8; t++) begin
        tick();
        if (d == 3 && t == 5) chk("scan_no_fd_on_latch", frame_done, 1'b0);
        if (d == 3 && t == 6) chk("scan_fd_after_latch", frame_done, 1'b1);
      end
    end
    chk("scan_digits", digits, 16'h4321);
    chk("scan_valid", digit_valid, 4'hF);
    chk("scan_fd_count", fd_cnt, 1);

    // Glitch of "2" inside a "1" dwell on digit 0; clr exposes the re-latch
    an  = 4'b1110;
    seg = pat[0];
    repeat (5) tick();
    chk("glitch_pre_digit", digits[3:0], 4'h1);
    seg = 7'b0100100;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("glitch_clr_valid", digit_valid, 4'h0);
    chk("glitch_g1", digits[3:0], 4'h1);
    tick();
    chk("glitch_g2", digits[3:0], 4'h1);
    tick();
    chk("glitch_g3", digits[3:0], 4'h1);
    seg = 7'b1111001;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("glitch_post_digit", digits[3:0], 4'h1);
      if (t == 4) chk("glitch_post_t4_valid", digit_valid, 4'h0);
    end
    chk("glitch_relatch_valid", digit_valid, 4'h1);

    // Illegal pattern on digit 1
    ce_cnt = 0;
    an     = 4'b1101;
    seg    = 7'b1010101;
    repeat (6) tick();
    chk("illegal_pulses", ce_cnt, 1);
    chk("illegal_err_flag", err_flag, 1'b1);
    chk("illegal_digit_kept", digits[7:4], 4'h2);
    chk("illegal_pulse_ended", code_err, 1'b0);
    chk("illegal_valid", digit_valid, 4'h1);

    // Dash on digit 2
    ce_cnt = 0;
    an     = 4'b1011;
    seg    = 7'b0111111;
    repeat (6) tick();
    chk("dash_digit", digits[11:8], 4'hF);
    chk("dash_no_err", ce_cnt, 0);
    chk("dash_err_sticky", err_flag, 1'b1);
    chk("dash_valid", digit_valid, 4'h5);

    // Blank segments
    an  = 4'b1110;
    seg = 7'b1111111;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err_flag", err_flag, 1'b0);
    chk("clr_valid", digit_valid, 4'h0);
    ce_cnt = 0;
    repeat (20) tick();
    chk("blank_valid", digit_valid, 4'h0);
    chk("blank_no_err", ce_cnt, 0);
    chk("blank_digits", digits, 16'h4F21);

    // Two anodes low with a legal pattern
    an  = 4'b1100;
    seg = 7'b0000000;
    repeat (20) tick();
    chk("nohot_cnt", dut.cnt_q, 8'd0);
    chk("nohot_valid", digit_valid, 4'h0);
    chk("nohot_no_err", ce_cnt, 0);
    chk("nohot_digits", digits, 16'h4F21);

    // clr colliding with a latch on digit 3
    an  = 4'b1110;
    seg = 7'b0010000;
    repeat (5) tick();
    chk("pre_coll_valid", digit_valid, 4'h1);
    chk("pre_coll_digit", digits[3:0], 4'h9);
    fd_cnt = 0;
    an     = 4'b0111;
    seg    = 7'b1111000;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("coll_digit", digits[15:12], 4'h7);
    chk("coll_valid", digit_valid, 4'h0);
    chk("coll_err_flag", err_flag, 1'b0);
    repeat (3) tick();
    chk("coll_no_fd", fd_cnt, 0);
    chk("coll_digits", digits, 16'h7F29);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Reads back a multiplexed, active-low, common-anode seven-segment display bus (segment lines plus per-digit anode enables) and recovers the BCD digit shown on each position.
- Sits on the display side of the board as a self-check/monitor for the segment driver path. It can also feed captured values into the scoreboards and UART debug dump.
- Filters anode-scan glitches with a stability counter.
- Reports per-digit values, validity, illegal patterns, and a frame-complete pulse.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is latched (2..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg  input  7  segment lines, active-low, bit0=a … bit6=g.
- an  input  NUM_DIGITS  digit enables, active-low; exactly one low = digit i selected.
- clr  input  1  synchronous clear of digit_valid, err_flag and the frame mask; digits keep their values.
- digits  output  4*NUM_DIGITS  latched value of digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set once digit i has been latched since reset/clr.
- code_err  output  1  one-cycle pulse when an illegal pattern passes the stability filter.
- err_flag  output  1  sticky OR of code_err; cleared by rst_n or clr.
- frame_done  output  1  one-cycle pulse when every digit has latched at least once since the last frame_done/reset/clr.

Behaviour:
- Reset (rst_n low at an edge):
  - digits=0, digit_valid=0, code_err=0, err_flag=0, frame_done=0.
  - Seen mask=0, counter=0, state=IDLE, sample registers=all ones.
- Input stage:
  - seg and an are registered every cycle into s_seg and s_an, with no synchroniser; the driver is on the same clock.
  - The previous registered pair is kept for comparison.
- Decode of s_seg (one-hot digit only):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4.
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 0111111 (dash) → 4'hF, legal.
  - 1111111 (blank) → ignored: no latch, no error.
  - Any other pattern → illegal.
- Counter cnt (8 bit, saturating at STABLE_CYCLES):
  - If s_an is one-hot-low and (s_seg,s_an) equals the previous pair, cnt+1.
  - Else if s_an is one-hot-low, cnt=1.
  - Else cnt=0.
- FSM states: IDLE, TRACK, HELD.
  - IDLE: s_an not one-hot (all high, or two or more low). Go to TRACK when one-hot.
  - TRACK: when cnt reaches STABLE_CYCLES, act on the pattern, then go to HELD:
    - legal: write digits[i], set digit_valid[i] and seen[i];
    - illegal: pulse code_err, set err_flag, leave digits[i] unchanged;
    - blank: no action.
  - HELD: no further action while the pair stays unchanged. Any change goes to TRACK with cnt=1; loss of one-hot goes to IDLE.
- Latency: with inputs held constant from before edge 1, cnt=STABLE_CYCLES after edge STABLE_CYCLES. Outputs update on edge STABLE_CYCLES+1 (5 cycles for the default).
- Pulses shorter than STABLE_CYCLES samples never latch.
- Dwell: a digit held indefinitely latches exactly once per dwell. A new value on the same digit re-arms after a seg change.
- Frame:
  - When the seen mask becomes all ones, frame_done pulses on the following edge and the mask clears in the same edge.
  - A latch arriving on that same edge sets its bit into the freshly cleared mask.
- Simultaneous events:
  - clr and a latch in the same cycle: clr wins for valid, err and mask, but digits[i] is still written.
  - rst_n overrides everything.
  - Reset mid-dwell restarts filtering from IDLE.
- NUM_DIGITS=1: frame_done pulses after every legal latch.

Test Plan:
- Reset: hold rst_n low 3 cycles with seg=0000000, an=1110 → all outputs 0. Then release and hold 5 cycles → digits[3:0]=8, digit_valid=0001 on edge 5 exactly.
- Scan: an cycles 1110/1101/1011/0111 with patterns for 1,2,3,4, 8 cycles each → digits=16'h4321, digit_valid=1111. frame_done pulses once, one cycle after the 4th latch.
- Glitch: the 3-cycle pattern 0100100 inside a 10-cycle 1111001 dwell on digit 0 → digits[3:0] is never 2. It stays 1; a second latch of 1 occurs after the glitch ends.
- Illegal and dash: 1010101 on digit 1 for 6 cycles → one code_err pulse, err_flag=1, digits[7:4] unchanged. 0111111 on digit 2 → digits[11:8]=F, no error.
- Blank and non-one-hot: seg=1111111 on any digit, or an=1100 with a legal seg, for 20 cycles → no latch, no error, cnt stays 0 for an=1100.
- clr collision: assert clr on the exact edge digit 3 latches 7 → digits[15:12]=7, digit_valid=0000, err_flag=0, no frame_done.
